// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_divider_pkg

// File: rtl/div_qreg.sv
// Quotient shift register: parallel load of the dividend, then one left
// shift per iteration with the new quotient bit entering at bit 0.
module div_qreg
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // Load has priority over shift; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {q_q[WIDTH-2:0], serial_i};
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : div_qreg

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE, out_valid only in DONE; the producer may
// hold in_valid and the consumer may hold out_ready low for any time, and
// the result outputs stay stable until the next result is loaded.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_t           state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] q_cur;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic             accept;
  logic             div_zero;
  logic             last_iter;

  assign accept    = in_valid && (state_q == IDLE);
  assign div_zero  = (divisor == '0);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // {R,Q} shifted left by one, with one extra guard bit so the trial
  // subtraction's sign is simply its MSB.
  assign r_shift  = {r_q, q_cur[WIDTH-1]};
  assign trial    = r_shift - {2'b00, d_q};
  assign trial_ok = ~trial[WIDTH+1];
  assign q_next   = {q_cur[WIDTH-2:0], trial_ok};

  div_qreg #(.WIDTH(WIDTH)) u_qreg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .load_val_i(dividend),
    .shift_i   (state_q == CALC),
    .serial_i  (trial_ok),
    .q_o       (q_cur)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = div_zero ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    state_o   = state_q;
  end

  // Datapath next-state: operand capture, iteration step, result load.
  always_comb begin
    r_d    = r_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (accept) begin
      r_d   = '0;
      d_d   = divisor;
      cnt_d = '0;
      if (div_zero) begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end
    end else if (state_q == CALC) begin
      r_d   = trial_ok ? trial[WIDTH:0] : r_shift[WIDTH:0];
      cnt_d = cnt_q + 1'b1;
      if (last_iter) begin
        quot_d = q_next;
        rem_d  = r_d[WIDTH-1:0];
        dbz_d  = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  dividend/divisor presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port dividend  input  WIDTH  unsigned dividend.
REQ-007 SHALL have port divisor  input  WIDTH  unsigned divisor.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port quotient  output  WIDTH  unsigned quotient.
REQ-011 SHALL have port remainder  output  WIDTH  unsigned remainder.
REQ-012 SHALL have port div_by_zero  output  1  result came from a zero divisor.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE; one operation in flight at a time.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept operands on a rising edge where in_valid && in_ready, registering dividend into Q and divisor into D, clearing the partial remainder R (WIDTH+1 bits) and the iteration counter.
REQ-016 On acceptance with divisor != 0, SHALL enter CALC; on divisor == 0, SHALL enter DONE directly with quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-017 In CALC, each cycle SHALL shift {R,Q} left by one, compute trial = R - {0,D}, and, if trial is non-negative, load R with trial and set Q[0]=1; otherwise set Q[0]=0 and keep R.
REQ-018 CALC SHALL last exactly WIDTH cycles; out_valid SHALL first be visible after the WIDTH-th edge following the acceptance edge (8 for WIDTH=8), or after 1 edge for a zero divisor.
REQ-019 On entering DONE, SHALL load quotient from Q, remainder from R[WIDTH-1:0], and div_by_zero from the zero-divisor test.
REQ-020 In DONE, SHALL hold all outputs stable while out_ready=0, for any number of cycles.
REQ-021 On an edge where out_valid && out_ready, SHALL return to IDLE; in_ready SHALL rise in the following cycle (no same-cycle accept).
REQ-022 quotient, remainder and div_by_zero SHALL retain the last result after the handshake until the next result loads.
REQ-023 in_valid, dividend and divisor SHALL be ignored outside IDLE; changes during CALC SHALL NOT affect the result.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor, including dividend < divisor (quotient 0) and divisor 1.

Reset
REQ-025 reset SHALL, at the next rising edge, force IDLE and clear Q, R, D, the counter, quotient, remainder and div_by_zero to 0; in_ready=1, out_valid=0.
REQ-026 reset SHALL take priority over every handshake, and over out_valid && out_ready in the same cycle.
REQ-027 reset asserted mid-CALC or in DONE SHALL abandon the operation without producing out_valid.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-029 The quotient shift register (parallel load, left shift with serial-in bit, synchronous reset) SHALL be a sub-module named div_qreg; the FSM, remainder datapath and counter SHALL stay in seq_divider.

Verification
REQ-030 Bench: 100 / 7 accepted -> out_valid exactly 8 cycles later, quotient 14, remainder 2, div_by_zero 0.
REQ-031 Bench: 255/1 -> 255 r 0; 5/10 -> 0 r 5; 255/255 -> 1 r 0; 0/3 -> 0 r 0.
REQ-032 Bench: 5 / 0 -> out_valid after 1 cycle, quotient 8'hFF, remainder 5, div_by_zero 1.
REQ-033 Bench: out_ready held 0 for 3 cycles in DONE -> outputs unchanged and in_ready 0; out_ready=1 -> IDLE next cycle.
REQ-034 Bench: operands toggled during CALC -> result unchanged; reset asserted at CALC cycle 4 -> IDLE next edge, all outputs 0, no out_valid.
REQ-035 Bench: 200 random nonzero-divisor pairs checked against a reference model with back-to-back transactions.
